au_sub_dserial: RTL

Digit-serial binary subtractor with borrow-in and borrow-out. It computes d = a − b − bi (mod 2^WIDTH) and bo = (a < b + bi), treating all operands as unsigned. Each operation takes N = ceil(WIDTH/DIGIT) clock cycles, processing one DIGIT-bit slice per cycle through a registered borrow chain. It is the sequential, area-reduced counterpart of the arithmetic unit's combinational fast-carry adder. Operands enter and results leave through valid/ready handshakes.

---
 rtl/au_sub_dserial_if.sv | 24 ++
 rtl/au_sub_dserial.sv | 97 +++++++++
 2 files changed

// File: rtl/au_sub_dserial_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
interface au_sub_dserial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bo;

  modport master (
    output in_valid, a, b, bi, out_ready,
    input  in_ready, out_valid, d, bo
  );

  modport slave (
    input  in_valid, a, b, bi, out_ready,
    output in_ready, out_valid, d, bo
  );
endinterface

// File: rtl/au_sub_dserial.sv
// Digit-serial unsigned subtractor: {bo, d} = a - b - bi, one DIGIT-bit slice
// per cycle through a registered borrow, valid/ready on both sides.
module au_sub_dserial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input logic            clk,
  input logic            rst_n,
  au_sub_dserial_if.slave bus
);
  localparam int unsigned N      = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int unsigned PW     = N * DIGIT;
  localparam int unsigned KW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic [DIGIT:0]   step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      k_q      <= k_d;
      d_q      <= d_d;
      bo_q     <= bo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)     state_d = CALC;
      CALC:    if (k_q == K_LAST)    state_d = DONE;
      DONE:    if (bus.out_ready)    state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Operands shift down one digit per cycle, so the active digit is always
  // the low slice; the result is steered into place by the digit counter.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    k_d      = k_q;
    d_d      = d_q;
    bo_d     = bo_q;
    step     = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
             - {{DIGIT{1'b0}}, borrow_q};
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = PW'(bus.a);
          b_d      = PW'(bus.b);
          borrow_d = bus.bi;
          k_d      = '0;
        end
      end
      CALC: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        borrow_d = step[DIGIT];
        k_d      = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (k_q == KW'(i / DIGIT)) d_d[i] = step[i % DIGIT];
        end
        if (k_q == K_LAST) bo_d = step[DIGIT];
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.d         = d_q;
    bus.bo        = bo_q;
  end
endmodule
